mem_read_arbiter: RTL and testbench
===================================

# mem_read_arbiter

Round-robin read scheduler that shares one `memory_block` read port between `NUM_REQ` requesters. It issues at most one read per cycle and tracks each read with a fixed-latency tag pipeline that matches the memory read latency. It returns each result to its originating requester as a one-hot valid pulse. Per-requester credit counters prevent any requester from having more reads outstanding than its downstream response FIFO can hold.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATAW`, 8, memory word width
- `ADDRW`, 9, memory address width
- `RD_LATENCY`, 2, cycles from `memory_block` sampling `raddr` to `rdata` valid (2 for `memory_block`)
- `CREDITS`, 4, response slots per requester (≥1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  read request per requester
- `req_addr`  in  NUM_REQ*ADDRW  request addresses; requester i occupies bits [i*ADDRW +: ADDRW]
- `req_ready`  out  NUM_REQ  one-hot grant, combinational
- `mem_raddr`  out  ADDRW  registered read address to `memory_block.raddr`
- `mem_rdata`  in  DATAW  from `memory_block.rdata`
- `rsp_valid`  out  NUM_REQ  one-hot response strobe
- `rsp_data`  out  DATAW  response data, shared by all requesters; equals `mem_rdata`
- `credit_return`  in  NUM_REQ  pulse: requester i freed one response slot
- `busy`  out  1  at least one read in flight

## Operation
- Requester i is eligible when `req_valid[i]` && `credit[i] != 0`.
- Arbitration is round-robin and starts at index `last_grant+1` (modulo `NUM_REQ`). The first eligible index is granted.
- `req_ready` is one-hot on that index, or all-zero if nothing is eligible. A handshake is `req_valid[i] && req_ready[i]`.
- On a handshake:
  - `mem_raddr` <= `req_addr[i]`.
  - `last_grant` <= i.
  - Tag {valid=1, id=i} enters stage 0 of the tag pipeline.
  - `credit[i]` is decremented.
- With no handshake, `mem_raddr` holds its value and an invalid tag enters the pipeline.
- The tag pipeline has depth `1+RD_LATENCY`. At its output, `rsp_valid = valid ? (1<<id) : 0`.
- Credits:
  - Each requester has a counter of width $clog2(CREDITS+1); reset value is `CREDITS`.
  - Grant and return in the same cycle: counter unchanged.
  - Return while the counter equals `CREDITS`: ignored (saturates).
- `busy` = OR of all tag-pipeline valid bits.
- Requesters must hold `req_valid` and `req_addr` stable until ready. The block does not check this.
- Reset mid-operation:
  - All tags are cleared, so in-flight responses are dropped and no `rsp_valid` pulses follow.
  - Credits return to `CREDITS` and `last_grant` returns to `NUM_REQ-1`.

## Timing
- Reset values:
  - `mem_raddr`=0, `rsp_valid`=0, `busy`=0.
  - `last_grant`=`NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready` is 0 during reset and combinational afterwards.
- Handshake in cycle t:
  - `mem_raddr` is valid in t+1.
  - `memory_block` registers the address at the end of t+1.
  - `rsp_valid`/`rsp_data` are valid in cycle t+1+RD_LATENCY (t+3 by default).
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses in grant order.
- `rsp_valid` is a single-cycle pulse. There is no response backpressure; credits guarantee space downstream.
- A credit returned at the end of cycle t makes the requester eligible in t+1.

## Test plan
- Single read: memory preloaded mem[5]=0xA7; requester 2 requests addr 5 in cycle 10 -> `req_ready`=0b0100 in cycle 10, `mem_raddr`=5 in cycle 11, `rsp_valid`=0b0100 with `rsp_data`=0xA7 in cycle 13, `busy` high for cycles 11-13.
- Contention: all four requesters valid from cycle 0 after reset, addrs 0-3 holding 0x10-0x13 -> grants 0,1,2,3 in cycles 0-3, responses 0x10..0x13 in cycles 3-6 with matching one-hot `rsp_valid`.
- Fairness: requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3; neither goes more than 1 cycle without a grant.
- Credit exhaustion: `CREDITS`=4, requester 0 always valid, no returns -> exactly 4 grants, then `req_ready[0]`=0. One `credit_return[0]` pulse -> exactly one more grant on the next cycle.
- Simultaneous grant + return on requester 0 at credit 2 -> credit stays 2. A return at credit 4 leaves credit at 4.
- Reset mid-flight: assert `rst` one cycle after two grants -> no `rsp_valid` afterwards, `busy`=0. The first request after reset is granted to requester 0 if it is valid.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin scheduler sharing one memory_block read port
// between NUM_REQ requesters. A tag pipeline matched to the memory read
// latency routes each returning word back to its requester. Per-requester
// credits bound the number of outstanding reads to the downstream FIFO depth.
module mem_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATAW      = 8,
    parameter int ADDRW      = 9,
    parameter int RD_LATENCY = 2,
    parameter int CREDITS    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ADDRW-1:0] req_addr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [ADDRW-1:0]         mem_raddr,
    input  logic [DATAW-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATAW-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]       credit_return,
    output logic                     busy
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CW    = $clog2(CREDITS + 1);
    localparam int DEPTH = 1 + RD_LATENCY;

    localparam logic [CW-1:0]  CREDIT_MAX = CW'(CREDITS);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  CREDIT_ONE = CW'(1);

    logic [IDW-1:0]     last_grant;
    logic [CW-1:0]      credit [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               handshake;
    logic [ADDRW-1:0]   grant_addr;
    logic [DEPTH-1:0]   tag_valid;
    logic [IDW-1:0]     tag_id [DEPTH];

    // A requester may compete only while it holds at least one credit.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (credit[i] != '0);
        end
    end

    // Round-robin search starting just after the last granted index.
    always_comb begin
        logic           found;
        int unsigned    idx;
        logic [IDW-1:0] idx_n;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_n     = '0;
        if (!rst) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx   = (32'(last_grant) + k) % NUM_REQ;
                idx_n = IDW'(idx);
                if (!found && eligible[idx_n]) begin
                    grant[idx_n] = 1'b1;
                    grant_idx    = idx_n;
                    found        = 1'b1;
                end
            end
        end
    end

    // Select the address of the granted requester.
    always_comb begin
        grant_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_addr = req_addr[i*ADDRW +: ADDRW];
            end
        end
    end

    assign handshake = |(grant & req_valid);
    assign req_ready = grant;

    // Register the read address and remember the winner for the next search.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_raddr  <= '0;
            last_grant <= LAST_RST;
        end else if (handshake) begin
            mem_raddr  <= grant_addr;
            last_grant <= grant_idx;
        end
    end

    // Tag pipeline: one slot per cycle, aligned with the memory read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], handshake};
            tag_id[0] <= grant_idx;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // Credits: grant consumes, return refills (saturating), both cancel.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                credit[i] <= CREDIT_MAX;
            end else if (grant[i] && !credit_return[i]) begin
                credit[i] <= credit[i] - CREDIT_ONE;
            end else if (!grant[i] && credit_return[i] && (credit[i] != CREDIT_MAX)) begin
                credit[i] <= credit[i] + CREDIT_ONE;
            end
        end
    end

    // Decode the tag leaving the pipeline into a one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        if (tag_valid[DEPTH-1]) begin
            rsp_valid[tag_id[DEPTH-1]] = 1'b1;
        end
    end

    assign rsp_data = mem_rdata;
    assign busy     = |tag_valid;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: behavioural memory_block, reference model of
// arbitration/credits, and a response scoreboard.
module tb_mem_read_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATAW      = 8;
    localparam int ADDRW      = 9;
    localparam int RD_LATENCY = 2;
    localparam int CREDITS    = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*ADDRW-1:0] req_addr;
    logic [NUM_REQ-1:0]       req_ready;
    logic [ADDRW-1:0]         mem_raddr;
    logic [DATAW-1:0]         mem_rdata;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [DATAW-1:0]         rsp_data;
    logic [NUM_REQ-1:0]       credit_return;
    logic                     busy;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATAW(DATAW),
        .ADDRW(ADDRW),
        .RD_LATENCY(RD_LATENCY),
        .CREDITS(CREDITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .credit_return(credit_return),
        .busy(busy)
    );

    // memory_block model: address registered, then data registered.
    logic [DATAW-1:0] mem [0:(1<<ADDRW)-1];
    logic [ADDRW-1:0] mem_a_q = '0;
    logic [DATAW-1:0] mem_d_q = '0;
    always @(posedge clk) begin
        mem_a_q <= mem_raddr;
        mem_d_q <= mem[mem_a_q];
    end
    assign mem_rdata = mem_d_q;

    typedef struct {
        int               id;
        logic [DATAW-1:0] data;
        int               due;
    } exp_t;

    exp_t            sb[$];
    int              m_credit [NUM_REQ];
    int              m_last = NUM_REQ - 1;
    int              hist = 0;
    logic [ADDRW-1:0] m_raddr = '0;
    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_grant();
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (m_last + k) % NUM_REQ;
            if (req_valid[i] && m_credit[i] > 0) return i;
        end
        return -1;
    endfunction

    // One clock cycle: compare outputs mid-cycle, advance the model, step.
    task automatic tick(output logic [NUM_REQ-1:0] rdy);
        int                 eg;
        logic [NUM_REQ-1:0] exp_ready;
        exp_t               e;
        @(negedge clk);
        eg = rst ? -1 : ref_grant();
        exp_ready = '0;
        if (eg >= 0) exp_ready[eg] = 1'b1;
        rdy = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mem_raddr", 32'(mem_raddr), 32'(m_raddr));
        check("busy", 32'(busy), 32'((hist & 7) != 0));
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("rsp_missing", 32'(rsp_valid), 32'(1) << sb[0].id);
            void'(sb.pop_front());
        end
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) m_credit[i] = CREDITS;
            m_last  = NUM_REQ - 1;
            m_raddr = '0;
            hist    = 0;
            sb.delete();
        end else begin
            hist = (hist << 1) & 7;
            if (eg >= 0) begin
                e.id   = eg;
                m_raddr = req_addr[eg*ADDRW +: ADDRW];
                e.data = mem[m_raddr];
                e.due  = cyc + 1 + RD_LATENCY;
                sb.push_back(e);
                m_last = eg;
                hist   = hist | 1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (eg == i && !credit_return[i]) m_credit[i]--;
                else if (eg != i && credit_return[i] && m_credit[i] < CREDITS) m_credit[i]++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input int a);
        req_addr[i*ADDRW +: ADDRW] = ADDRW'(a);
    endtask

    logic [NUM_REQ-1:0] rdy;
    int                 n;

    initial begin
        for (int i = 0; i < (1 << ADDRW); i++) mem[i] = DATAW'(i * 7 + 3);
        mem[5] = 8'hA7;
        for (int i = 0; i < 4; i++) mem[i] = DATAW'(8'h10 + i);
        for (int i = 0; i < NUM_REQ; i++) m_credit[i] = CREDITS;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        credit_return = '0;
        tick(rdy);
        tick(rdy);
        rst = 1'b0;
        tick(rdy);

        // Single read by requester 2 from address 5.
        req_valid = 4'b0100;
        set_addr(2, 5);
        tick(rdy);
        check("t1_ready", 32'(rdy), 32'h4);
        req_valid = '0;
        check("t1_raddr", 32'(mem_raddr), 32'd5);
        for (int k = 0; k < 4; k++) tick(rdy);

        // Contention straight out of reset.
        rst = 1'b1;
        tick(rdy);
        rst = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 4; i++) set_addr(i, i);
        for (int i = 0; i < 4; i++) begin
            tick(rdy);
            check("t2_grant", 32'(rdy), 32'(1) << i);
            req_valid[i] = 1'b0;
        end
        credit_return = '1;
        tick(rdy);
        credit_return = '0;
        for (int k = 0; k < 4; k++) tick(rdy);

        // Fairness between requesters 1 and 3.
        set_addr(1, 40);
        set_addr(3, 77);
        req_valid = 4'b1010;
        credit_return = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            tick(rdy);
            check("t3_alt", 32'(rdy), (k % 2 == 0) ? 32'h2 : 32'h8);
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick(rdy);
        credit_return = '0;

        // Credit exhaustion on requester 0.
        set_addr(0, 9);
        req_valid = 4'b0001;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick(rdy);
            n += int'(rdy[0]);
        end
        check("t4_grants", n, 4);
        check("t4_blocked", 32'(rdy), 32'h0);
        credit_return = 4'b0001;
        tick(rdy);
        check("t4_ret_cycle", 32'(rdy), 32'h0);
        credit_return = '0;
        tick(rdy);
        check("t4_regrant", 32'(rdy), 32'h1);
        tick(rdy);
        check("t4_after", 32'(rdy), 32'h0);

        // Grant and return together at credit 2; saturation at 4.
        req_valid = '0;
        credit_return = 4'b0001;
        tick(rdy);
        tick(rdy);
        req_valid = 4'b0001;
        tick(rdy);
        check("t5_both", 32'(rdy), 32'h1);
        credit_return = '0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick(rdy);
            n += int'(rdy[0]);
        end
        check("t5_after_both", n, 2);
        req_valid = '0;
        credit_return = 4'b0001;
        for (int k = 0; k < 6; k++) tick(rdy);
        credit_return = '0;
        req_valid = 4'b0001;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick(rdy);
            n += int'(rdy[0]);
        end
        check("t5_saturate", n, 4);
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick(rdy);

        // Reset with two reads in flight.
        set_addr(1, 100);
        set_addr(2, 200);
        req_valid = 4'b0110;
        tick(rdy);
        tick(rdy);
        req_valid = '0;
        rst = 1'b1;
        tick(rdy);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rsp", 32'(rsp_valid), 32'd0);
        set_addr(0, 3);
        set_addr(3, 4);
        req_valid = 4'b1101;
        tick(rdy);
        check("t6_first", 32'(rdy), 32'h1);
        req_valid = '0;
        for (int k = 0; k < 5; k++) tick(rdy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
